// File: rtl/dco_bank.sv
// dco_bank: bank of independent digitally controlled oscillators.
// Each channel divides clk_i by 2*H, where the half period H is retuned by
// load / increment / decrement requests, and reports lock once H has been
// left alone for LOCK_CNT rising output edges.
module dco_bank #(
  parameter int NUM_CH     = 2,
  parameter int PERIOD_W   = 16,
  parameter int STEP_W     = 8,
  parameter int MIN_HALF   = 2,
  parameter int MAX_HALF   = 1000,
  parameter int RESET_HALF = 10,
  parameter int LOCK_CNT   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            en_i,
  input  logic [NUM_CH-1:0]            incr_i,
  input  logic [NUM_CH-1:0]            decr_i,
  input  logic [NUM_CH*STEP_W-1:0]     step_i,
  input  logic [NUM_CH-1:0]            load_i,
  input  logic [NUM_CH*PERIOD_W-1:0]   load_half_i,
  output logic [NUM_CH-1:0]            clk_o,
  output logic [NUM_CH-1:0]            tick_o,
  output logic [NUM_CH*PERIOD_W-1:0]   half_o,
  output logic [NUM_CH-1:0]            locked_o
);

  // Update arithmetic is done two bits wider and signed so that neither
  // H - step nor a full-scale load can wrap before saturation.
  localparam int AW = PERIOD_W + 2;
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic signed [AW-1:0]   MIN_S    = AW'(MIN_HALF);
  localparam logic signed [AW-1:0]   MAX_S    = AW'(MAX_HALF);
  localparam logic [PERIOD_W-1:0]    MIN_H    = PERIOD_W'(MIN_HALF);
  localparam logic [PERIOD_W-1:0]    MAX_H    = PERIOD_W'(MAX_HALF);
  localparam logic [PERIOD_W-1:0]    RST_H    = PERIOD_W'(RESET_HALF);
  localparam logic [LW-1:0]          LOCK_MAX = LW'(LOCK_CNT);

  // Saturate a wide signed candidate half period into [MIN_HALF, MAX_HALF].
  function automatic logic [PERIOD_W-1:0] sat_half(input logic signed [AW-1:0] v);
    if (v < MIN_S)      return MIN_H;
    else if (v > MAX_S) return MAX_H;
    else                return v[PERIOD_W-1:0];
  endfunction

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [PERIOD_W-1:0]   r_half;
    logic [PERIOD_W-1:0]   r_cnt;
    logic                  r_clk;
    logic                  r_tick;
    logic [LW-1:0]         r_lock_cnt;
    logic                  r_locked;

    logic signed [AW-1:0]  w_half_s;
    logic signed [AW-1:0]  w_step_s;
    logic signed [AW-1:0]  w_load_s;
    logic [PERIOD_W-1:0]   w_half_nxt;
    logic                  w_adj;
    logic [PERIOD_W:0]     w_cnt_inc;
    logic                  w_fire;
    logic                  w_rise;
    logic [LW-1:0]         w_lock_inc;

    // Next half period: load beats a single-sided adjust; incr+decr cancel.
    always_comb begin
      w_half_s   = signed'({2'b00, r_half});
      w_step_s   = signed'({{(AW-STEP_W){1'b0}}, step_i[n*STEP_W +: STEP_W]});
      w_load_s   = signed'({2'b00, load_half_i[n*PERIOD_W +: PERIOD_W]});
      w_half_nxt = r_half;
      if (load_i[n]) begin
        w_half_nxt = sat_half(w_load_s);
      end else if (incr_i[n] ^ decr_i[n]) begin
        if (incr_i[n]) w_half_nxt = sat_half(w_half_s - w_step_s);
        else           w_half_nxt = sat_half(w_half_s + w_step_s);
      end
      // Only a real change of H counts as retuning; clamped or zero-step
      // requests leave the lock undisturbed.
      w_adj = (w_half_nxt != r_half);
    end

    // Toggle decision against the registered H; ">=" makes a shrink below
    // the running count fire immediately instead of wrapping.
    always_comb begin
      w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
      w_fire     = (w_cnt_inc >= {1'b0, r_half});
      w_rise     = w_fire & ~r_clk;
      w_lock_inc = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + 1'b1;
    end

    // Channel state: half period, divider counter, output clock and lock.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_half     <= RST_H;
        r_cnt      <= '0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end else begin
        r_half <= w_half_nxt;
        if (!en_i[n]) begin
          r_cnt      <= '0;
          r_clk      <= 1'b0;
          r_tick     <= 1'b0;
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
        end else begin
          if (w_fire) begin
            r_clk  <= ~r_clk;
            r_tick <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_tick <= 1'b0;
            r_cnt  <= w_cnt_inc[PERIOD_W-1:0];
          end
          if (w_adj) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
          end else if (w_rise) begin
            r_lock_cnt <= w_lock_inc;
            r_locked   <= (w_lock_inc == LOCK_MAX);
          end
        end
      end
    end

    assign clk_o[n]                        = r_clk;
    assign tick_o[n]                       = r_tick;
    assign half_o[n*PERIOD_W +: PERIOD_W]  = r_half;
    assign locked_o[n]                     = r_locked;
  end

endmodule
